// File: rtl/melody_sequencer.sv
// Plays a fixed 14-entry tune from ROM as one-hot note selects for the sine synth.
// Each entry is followed by an all-zero gap so that a repeated note retriggers.
module melody_sequencer #(
    parameter int TEMPO_DIV  = 12500000,
    parameter int GAP_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [7:0] notes,
    output logic       busy,
    output logic [3:0] step,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [23:0] PRESC_LAST = 24'(TEMPO_DIV - 1);
    localparam logic [19:0] GAP_LAST   = 20'(GAP_CYCLES - 1);

    // Entry layout: {end, rest, dur[1:0], note[2:0]}; length is dur+1 beats.
    function automatic logic [6:0] rom_entry(input logic [3:0] idx);
        logic [6:0] e;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: e = {1'b0, 1'b0, 2'd0, idx[2:0]};
            4'd8:    e = {1'b0, 1'b0, 2'd1, 3'd4};
            4'd9:    e = {1'b0, 1'b1, 2'd1, 3'd0};
            4'd10:   e = {1'b0, 1'b0, 2'd0, 3'd5};
            4'd11:   e = {1'b0, 1'b0, 2'd0, 3'd4};
            4'd12:   e = {1'b0, 1'b0, 2'd0, 3'd2};
            4'd13:   e = {1'b1, 1'b0, 2'd3, 3'd0};
            default: e = {1'b1, 1'b1, 2'd0, 3'd0};
        endcase
        return e;
    endfunction

    function automatic logic [7:0] onehot(input logic [6:0] e);
        return e[5] ? 8'h00 : (8'h01 << e[2:0]);
    endfunction

    state_t      state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [1:0]  beat_q,  beat_d;
    logic [19:0] gap_q,   gap_d;
    logic [3:0]  step_q,  step_d;
    logic [7:0]  notes_q, notes_d;
    logic        done_q,  done_d;

    logic [6:0] cur_entry;
    logic [6:0] next_entry;
    logic [6:0] first_entry;

    assign cur_entry   = rom_entry(step_q);
    assign next_entry  = rom_entry(step_q + 4'd1);
    assign first_entry = rom_entry(4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            step_q  <= '0;
            notes_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            step_q  <= step_d;
            notes_q <= notes_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        step_d  = step_q;
        notes_d = notes_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                notes_d = 8'h00;
                step_d  = 4'd0;
                if (start && !stop) begin
                    notes_d = onehot(first_entry);
                    presc_d = '0;
                    beat_d  = '0;
                    state_d = NOTE;
                end
            end

            NOTE: begin
                if (stop) begin
                    state_d = IDLE;
                    notes_d = 8'h00;
                    step_d  = 4'd0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (beat_q == cur_entry[4:3]) begin
                        notes_d = 8'h00;
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    presc_d = presc_q + 24'd1;
                end
            end

            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                    notes_d = 8'h00;
                    step_d  = 4'd0;
                end else if (gap_q == GAP_LAST) begin
                    presc_d = '0;
                    beat_d  = '0;
                    if (!cur_entry[6]) begin
                        step_d  = step_q + 4'd1;
                        notes_d = onehot(next_entry);
                        state_d = NOTE;
                    end else if (loop_en) begin
                        step_d  = 4'd0;
                        notes_d = onehot(first_entry);
                        state_d = NOTE;
                    end else begin
                        step_d  = 4'd0;
                        notes_d = 8'h00;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 20'd1;
                end
            end

            default: begin
                state_d = IDLE;
                notes_d = 8'h00;
                step_d  = 4'd0;
            end
        endcase
    end

    assign notes = notes_q;
    assign busy  = (state_q != IDLE);
    assign step  = step_q;
    assign done  = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios plus random start/stop/loop traffic,
// every cycle compared against a tune-timeline model indexed by cycles since playback start.
module tb_melody_sequencer;

    localparam int TD   = 8;
    localparam int GC   = 2;
    localparam int NENT = 14;

    logic       clk     = 1'b0;
    logic       clk_en  = 1'b0;
    logic       rst     = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] notes;
    logic       busy;
    logic [3:0] step;
    logic       done;

    melody_sequencer #(
        .TEMPO_DIV (TD),
        .GAP_CYCLES(GC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .loop_en(loop_en),
        .notes  (notes),
        .busy   (busy),
        .step   (step),
        .done   (done)
    );

    always #5 if (clk_en) clk = ~clk;

    int tune_note  [NENT] = '{0, 1, 2, 3, 4, 5, 6, 7, 4, 0, 5, 4, 2, 0};
    int tune_beats [NENT] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 1, 1, 1, 4};
    int tune_rest  [NENT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    int errors = 0;
    int checks = 0;
    int pass_len = 0;
    int mdl_active = 0;
    int mdl_pos = 0;
    int mdl_done = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected notes/step at a given cycle offset into one pass of the tune.
    function automatic void exp_at(input int pos, output int n, output int s);
        int p;
        p = pos;
        n = 0;
        s = 0;
        for (int i = 0; i < NENT; i++) begin
            if (p < tune_beats[i] * TD) begin
                n = tune_rest[i] ? 0 : (1 << tune_note[i]);
                s = i;
                return;
            end
            p -= tune_beats[i] * TD;
            if (p < GC) begin
                n = 0;
                s = i;
                return;
            end
            p -= GC;
        end
    endfunction

    task automatic compare_all();
        int en, es;
        en = 0;
        es = 0;
        if (mdl_active != 0) exp_at(mdl_pos, en, es);
        check_val("notes", int'(notes), en);
        check_val("busy",  int'(busy),  mdl_active);
        check_val("step",  int'(step),  es);
        check_val("done",  int'(done),  mdl_done);
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_done = 0;
        if (mdl_active == 0) begin
            if (start && !stop) begin
                mdl_active = 1;
                mdl_pos = 0;
                $display("t=%0t start: playback from entry 0", $time);
            end
        end else if (stop) begin
            mdl_active = 0;
            $display("t=%0t stop: playback aborted at pos %0d", $time, mdl_pos);
        end else if (mdl_pos == pass_len - 1) begin
            if (loop_en) begin
                mdl_pos = 0;
                $display("t=%0t loop: restarting at entry 0", $time);
            end else begin
                mdl_active = 0;
                mdl_done = 1;
                $display("t=%0t done: tune finished", $time);
            end
        end else begin
            mdl_pos++;
        end
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < NENT; i++) pass_len += tune_beats[i] * TD + GC;

        // Async reset with the clock held still
        #1 rst = 1'b1;
        #1 compare_all();
        #1 rst = 1'b0;
        clk_en = 1'b1;
        repeat (3) tick();

        // Full tune, single start pulse, no loop
        start = 1'b1; tick(); start = 1'b0;
        repeat (pass_len + 5) tick();

        // Stop during entry 3
        start = 1'b1; tick(); start = 1'b0;
        repeat (33) tick();
        check_val("entry3_notes", int'(notes), 8'h08);
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (3) tick();

        // start and stop together while idle
        start = 1'b1; stop = 1'b1;
        repeat (3) tick();
        start = 1'b0; stop = 1'b0;
        tick();

        // start held while busy, then relaunch after finish, then stop
        start = 1'b1;
        repeat (pass_len + 10) tick();
        start = 1'b0;
        repeat (20) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        tick();

        // Loop one pass, then clear loop_en during the second pass
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (pass_len + 20) tick();
        loop_en = 1'b0;
        repeat (pass_len) tick();

        // Async reset between edges during entry 8
        start = 1'b1; tick(); start = 1'b0;
        repeat (83) tick();
        check_val("entry8_notes", int'(notes), 8'h10);
        #2 rst = 1'b1;
        mdl_active = 0;
        mdl_done = 0;
        #1 compare_all();
        $display("t=%0t reset: asserted mid-tune", $time);
        #1 rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();

        // Random traffic
        repeat (3000) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 499) == 0) loop_en = ~loop_en;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage for the sine synthesizer.
- Plays a fixed 14-entry tune from an internal ROM and drives the synth's 8-bit one-hot note-select input.
- Because the synth triggers on rising edges of each note bit, every note is followed by an all-zero gap so that a repeated note retriggers.
- Tempo is derived from the system clock by a prescaler.

Parameters:
- TEMPO_DIV, 12500000: clock cycles per beat (0.25 s at 50 MHz). Legal range 2..2^24.
- GAP_CYCLES, 500000: cycles of all-zero output after every entry. Legal range 1..2^20.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  level, sampled each edge; begins playback from entry 0 when idle
- stop  input  1  level, sampled each edge; aborts playback
- loop_en  input  1  when 1, restart at entry 0 after the last entry instead of finishing
- notes  output  8  registered one-hot note select to the synth; bit0=C ... bit7=high C; 0 = silence
- busy  output  1  high in NOTE or GAP
- step  output  4  index of the current ROM entry
- done  output  1  one-cycle pulse when the tune ends without looping

Behaviour:
- Reset (async, rst=1): state=IDLE, notes=0, busy=0, step=0, done=0, prescaler=0, beat count=0.
- ROM entry format is {end, rest, dur[1:0], note[2:0]}. Length is (dur+1) beats. rest=1 gives notes=0 for the note phase.
- ROM contents:
  - 0-7: notes 0..7, 1 beat each
  - 8: note 4, 2 beats
  - 9: rest, 2 beats
  - 10: note 5, 1 beat
  - 11: note 4, 1 beat
  - 12: note 2, 1 beat
  - 13: note 0, 4 beats, end=1
  - 14-15: unused; read as rest, 1 beat, end=1
- Timing uses a prescaler (0..TEMPO_DIV-1) plus a 2-bit beat counter. The gap uses its own counter (0..GAP_CYCLES-1).
- IDLE:
  - notes=0, busy=0.
  - On the edge where start=1 and stop=0: step<=0, notes<=onehot(entry0), state<=NOTE, busy<=1. Counters clear on the same edge.
  - Result: notes=0x01 is visible one cycle after start is sampled.
- NOTE:
  - notes are held for exactly (dur+1)*TEMPO_DIV cycles.
  - On the final cycle: notes<=0, state<=GAP.
- GAP:
  - notes=0 for exactly GAP_CYCLES cycles.
  - On the final cycle, one of three outcomes:
    - end=0: step<=step+1, notes<=onehot(next entry) (or 0 if rest), state<=NOTE.
    - end=1 and loop_en=1: step<=0, load entry 0, state<=NOTE; no done pulse.
    - end=1 and loop_en=0: state<=IDLE, busy<=0, step<=0, done<=1 for one cycle.
  - loop_en is sampled only on that final GAP cycle.
- stop=1 in NOTE or GAP: next edge gives state=IDLE, notes=0, busy=0, step=0; no done pulse.
- Priority: stop beats start when both are high in the same cycle, including in IDLE.
- start while busy is ignored; playback is not restarted.
- In IDLE, start held high re-launches playback immediately after a tune finishes or is stopped.
- Only one notes bit is ever high at a time.
- Asserting rst mid-tune clears all outputs immediately, with no clock edge needed.

Test Plan:
- Reset: assert rst with clk stopped -> notes=0x00, busy=0, step=0, done=0 immediately.
- Basic sequence (TEMPO_DIV=8, GAP_CYCLES=2, loop_en=0): pulse start for 1 cycle ->
  - notes=0x01 for 8 cycles, then 0x00 for 2, then 0x02 for 8, and so on.
  - step steps 0,1,2... at each note start.
- Full tune, same parameters:
  - Entry 8 gives notes=0x10 for 16 cycles.
  - Entry 9 gives notes=0x00 for 16+2 cycles.
  - Entry 13 gives notes=0x01 for 32 cycles.
  - Exactly 180 cycles after notes first becomes 0x01: done pulses for 1 cycle, busy falls on the same edge, step=0.
- Loop: loop_en=1 -> after entry 13 and its gap, notes=0x01 again with step=0, done never asserted. Set loop_en=0 during the next pass -> done fires at the end of that pass.
- Stop and priority:
  - stop=1 during entry 3 (notes=0x08) -> next cycle notes=0x00, busy=0, step=0, no done.
  - start=1 together with stop=1 while idle -> stays IDLE.
  - start=1 while busy -> sequence timing unchanged.
- Async reset mid-tune: rst pulse during entry 8 (between clock edges) -> notes=0x00, busy=0, step=0 immediately. After release, the next start plays from entry 0.
